fft_peak_detect: RTL and testbench
==================================

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 Parameter FFT_SIZE, default 1024: bins per frame; power of two, at least 4.
REQ-002 Parameter DATA_WIDTH, default 16: signed width of each of re/im.
REQ-003 Parameter SKIP_DC, default 1: when 1, bin 0 is excluded from the peak search.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 fft_in_valid_i  input  1  complex bin beat valid.
REQ-007 fft_in_data_i  input  2*DATA_WIDTH  signed re in upper half, signed im in lower half.
REQ-008 fft_in_ready_o  output  1  block accepts a beat.
REQ-009 peak_valid_o  output  1  frame result available.
REQ-010 peak_ready_i  input  1  result consumer ready.
REQ-011 peak_idx_o  output  $clog2(FFT_SIZE)  index of the strongest eligible bin.
REQ-012 peak_pow_o  output  2*DATA_WIDTH  unsigned re^2+im^2 of the peak bin.
REQ-013 energy_o  output  2*DATA_WIDTH+$clog2(FFT_SIZE)  unsigned sum of re^2+im^2 over all bins, including bin 0.
REQ-014 frame_cnt_o  output  16  count of completed frames; wraps from 65535 to 0.

Function
REQ-015 A beat is accepted on a cycle with fft_in_valid_i and fft_in_ready_o both high; beats are bins 0..FFT_SIZE-1 in order.
REQ-016 FSM has two states: ACCUM, with fft_in_ready_o=1 and peak_valid_o=0, and REPORT, with fft_in_ready_o=0 and peak_valid_o=1.
REQ-017 ACCUM -> REPORT on acceptance of bin FFT_SIZE-1; REPORT -> ACCUM on any cycle with peak_ready_i=1.
REQ-018 peak_valid_o rises the cycle after bin FFT_SIZE-1 is accepted; latency is 1 cycle.
REQ-019 Power per bin is re*re+im*im computed exactly, with no truncation; the maximum 2^(2*DATA_WIDTH-1) fits in 2*DATA_WIDTH bits.
REQ-020 Peak registers start each frame at pow=0, idx=first eligible bin (0, or 1 if SKIP_DC); they update only when an eligible bin's pow is strictly greater, so the lowest index wins ties.
REQ-021 All-zero frame: peak_idx_o = first eligible bin, peak_pow_o=0, energy_o=0.
REQ-022 peak_idx_o, peak_pow_o, energy_o and frame_cnt_o are registered and held stable while in REPORT.
REQ-023 frame_cnt_o increments in the same cycle peak_valid_o rises.
REQ-024 Bin counter, peak and energy accumulators clear on the REPORT -> ACCUM transition; reported outputs keep their last values until the next report.
REQ-025 peak_ready_i high in the first REPORT cycle yields exactly one peak_valid_o cycle, with ACCUM the next cycle.
REQ-026 fft_in_valid_i during REPORT is ignored; no beat is consumed.

Reset
REQ-027 Asserting rst_ni forces: state ACCUM, fft_in_ready_o=1, peak_valid_o=0, peak_idx_o=0, peak_pow_o=0, energy_o=0, frame_cnt_o=0, bin counter=0.
REQ-028 Reset mid-frame discards the partial frame; the next frame reports only beats accepted after reset release.

Structure
REQ-029 The complex_t typedef (packed re/im, DATA_WIDTH) and width-derivation constants shall live in shared package fft_pkg, also used by fft_core.
REQ-030 Power computation shall be a combinational sub-module cplx_mag2 (signed complex in, unsigned 2*DATA_WIDTH out); the FSM and accumulators stay in fft_peak_detect.

Verification (FFT_SIZE=8, DATA_WIDTH=16, SKIP_DC=1 unless stated)
REQ-031 Bin3=(100,-50), others 0 -> peak_idx_o=3, peak_pow_o=12500, energy_o=12500, frame_cnt_o=1, valid 1 cycle after last beat.
REQ-032 Bins 2 and 5 = (10,0), others 0 -> peak_idx_o=2, peak_pow_o=100, energy_o=200.
REQ-033 Bin0=(1000,0), bin4=(3,4) -> peak_idx_o=4, peak_pow_o=25, energy_o=1000025; with SKIP_DC=0 -> peak_idx_o=0, peak_pow_o=1000000.
REQ-034 All bins (-32768,-32768) -> peak_idx_o=1, peak_pow_o=2147483648, energy_o=17179869184.
REQ-035 peak_ready_i held low 5 cycles after a report -> fft_in_ready_o=0 and outputs unchanged throughout; after release, the next 8-beat frame gives frame_cnt_o=2.
REQ-036 Reset asserted after 4 beats of a frame with bin2=(500,0), then a clean frame with bin6=(7,0) -> peak_idx_o=6, peak_pow_o=49, frame_cnt_o=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath types and width helpers.
package fft_pkg;

  localparam int unsigned CPLX_WIDTH = 16;

  typedef struct packed {
    logic signed [CPLX_WIDTH-1:0] re;
    logic signed [CPLX_WIDTH-1:0] im;
  } complex_t;

  typedef enum logic {
    PD_ACCUM  = 1'b0,
    PD_REPORT = 1'b1
  } pd_state_e;

  // |x|^2 of a signed complex sample needs exactly twice the component width.
  function automatic int unsigned pow_width(input int unsigned dw);
    return 2 * dw;
  endfunction

  // Frame energy gains log2(n) bits of headroom over a single bin's power.
  function automatic int unsigned energy_width(input int unsigned dw, input int unsigned n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/cplx_mag2.sv
// Exact squared magnitude re^2 + im^2 of a signed complex sample.
module cplx_mag2 #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0]   re_i,
  input  logic signed [DATA_WIDTH-1:0]   im_i,
  output logic        [2*DATA_WIDTH-1:0] pow_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] re_ext, im_ext, re_sq, im_sq;

  // Each square is at most 2^(PW-2), so it is non-negative as signed; the sum needs the full unsigned range.
  assign re_ext = PW'(re_i);
  assign im_ext = PW'(im_i);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign pow_o  = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak bin search and total energy over a stream of FFT bins.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int unsigned FFT_SIZE   = 1024,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SKIP_DC    = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          fft_in_valid_i,
  input  logic [2*DATA_WIDTH-1:0]                       fft_in_data_i,
  output logic                                          fft_in_ready_o,
  output logic                                          peak_valid_o,
  input  logic                                          peak_ready_i,
  output logic [$clog2(FFT_SIZE)-1:0]                   peak_idx_o,
  output logic [2*DATA_WIDTH-1:0]                       peak_pow_o,
  output logic [2*DATA_WIDTH+$clog2(FFT_SIZE)-1:0]      energy_o,
  output logic [15:0]                                   frame_cnt_o
);

  localparam int unsigned IDX_W = $clog2(FFT_SIZE);
  localparam int unsigned PW    = pow_width(DATA_WIDTH);
  localparam int unsigned EW    = energy_width(DATA_WIDTH, FFT_SIZE);
  localparam logic [IDX_W-1:0] FIRST_IDX = (SKIP_DC != 0) ? IDX_W'(1) : IDX_W'(0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FFT_SIZE - 1);

  pd_state_e          state_q, state_d;
  logic [IDX_W-1:0]   bin_q;
  logic [IDX_W-1:0]   peak_idx_q, peak_idx_nxt;
  logic [PW-1:0]      peak_pow_q, peak_pow_nxt;
  logic [EW-1:0]      energy_q, energy_nxt;
  logic [PW-1:0]      beat_pow;
  logic               accept, last_beat, eligible, clear;

  cplx_mag2 #(.DATA_WIDTH(DATA_WIDTH)) u_mag2 (
    .re_i  (fft_in_data_i[2*DATA_WIDTH-1:DATA_WIDTH]),
    .im_i  (fft_in_data_i[DATA_WIDTH-1:0]),
    .pow_o (beat_pow)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= PD_ACCUM;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    fft_in_ready_o = 1'b0;
    peak_valid_o   = 1'b0;
    unique case (state_q)
      PD_ACCUM: begin
        fft_in_ready_o = 1'b1;
        if (fft_in_valid_i && (bin_q == LAST_IDX)) state_d = PD_REPORT;
      end
      PD_REPORT: begin
        peak_valid_o = 1'b1;
        if (peak_ready_i) state_d = PD_ACCUM;
      end
    endcase
  end

  assign accept    = fft_in_valid_i && (state_q == PD_ACCUM);
  assign last_beat = (bin_q == LAST_IDX);
  assign clear     = (state_q == PD_REPORT) && peak_ready_i;
  assign eligible  = !((SKIP_DC != 0) && (bin_q == IDX_W'(0)));

  // Strictly-greater update keeps the lowest index on ties.
  always_comb begin
    peak_idx_nxt = peak_idx_q;
    peak_pow_nxt = peak_pow_q;
    if (eligible && (beat_pow > peak_pow_q)) begin
      peak_idx_nxt = bin_q;
      peak_pow_nxt = beat_pow;
    end
    energy_nxt = energy_q + EW'(beat_pow);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q       <= '0;
      peak_idx_q  <= FIRST_IDX;
      peak_pow_q  <= '0;
      energy_q    <= '0;
      peak_idx_o  <= '0;
      peak_pow_o  <= '0;
      energy_o    <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (clear) begin
        bin_q      <= '0;
        peak_idx_q <= FIRST_IDX;
        peak_pow_q <= '0;
        energy_q   <= '0;
      end else if (accept) begin
        bin_q      <= bin_q + IDX_W'(1);
        peak_idx_q <= peak_idx_nxt;
        peak_pow_q <= peak_pow_nxt;
        energy_q   <= energy_nxt;
      end
      // Results are captured with the last beat so they are valid when REPORT is entered.
      if (accept && last_beat) begin
        peak_idx_o  <= peak_idx_nxt;
        peak_pow_o  <= peak_pow_nxt;
        energy_o    <= energy_nxt;
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed and randomized frames against a reference model, SKIP_DC=1 and SKIP_DC=0 instances.
module tb_fft_peak_detect;
  import fft_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fft_in_valid;
  logic [31:0] fft_in_data;
  logic        peak_ready;

  logic        ready1, valid1, ready0, valid0;
  logic [2:0]  idx1, idx0;
  logic [31:0] pow1, pow0;
  logic [34:0] en1, en0;
  logic [15:0] cnt1, cnt0;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned exp_frames = 0;
  complex_t    frame [N];

  always #5 clk = ~clk;

  fft_peak_detect #(.FFT_SIZE(N), .DATA_WIDTH(DW), .SKIP_DC(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .fft_in_valid_i(fft_in_valid), .fft_in_data_i(fft_in_data),
    .fft_in_ready_o(ready1), .peak_valid_o(valid1), .peak_ready_i(peak_ready),
    .peak_idx_o(idx1), .peak_pow_o(pow1), .energy_o(en1), .frame_cnt_o(cnt1)
  );

  fft_peak_detect #(.FFT_SIZE(N), .DATA_WIDTH(DW), .SKIP_DC(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .fft_in_valid_i(fft_in_valid), .fft_in_data_i(fft_in_data),
    .fft_in_ready_o(ready0), .peak_valid_o(valid0), .peak_ready_i(peak_ready),
    .peak_idx_o(idx0), .peak_pow_o(pow0), .energy_o(en0), .frame_cnt_o(cnt0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint bin_pow(input complex_t c);
    longint re, im;
    re = longint'($signed(c.re));
    im = longint'($signed(c.im));
    return re * re + im * im;
  endfunction

  // Reference: scan the stored frame, strongest eligible bin wins, earliest on ties.
  task automatic model(input bit skip, output logic [63:0] idx, output logic [63:0] pw,
                       output logic [63:0] en);
    longint p, best, sum;
    best = 0; sum = 0;
    idx  = skip ? 64'd1 : 64'd0;
    for (int i = 0; i < N; i++) begin
      p = bin_pow(frame[i]);
      sum += p;
      if ((!skip || i != 0) && p > best) begin
        best = p;
        idx  = 64'(i);
      end
    end
    pw = 64'(best);
    en = 64'(sum);
  endtask

  task automatic zero_frame();
    for (int i = 0; i < N; i++) frame[i] = '0;
  endtask

  task automatic set_bin(input int i, input int re, input int im);
    frame[i].re = DW'(re);
    frame[i].im = DW'(im);
  endtask

  task automatic check_reset();
    chk("rst_ready", ready1, 1);   chk("rst_valid", valid1, 0);
    chk("rst_idx", idx1, 0);       chk("rst_pow", pow1, 0);
    chk("rst_energy", en1, 0);     chk("rst_cnt", cnt1, 0);
    chk("rst_ready0", ready0, 1);  chk("rst_valid0", valid0, 0);
    chk("rst_cnt0", cnt0, 0);
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("beat_ready", ready1, 1);
      fft_in_valid = 1'b1;
      fft_in_data  = frame[i];
    end
  endtask

  task automatic check_report(input string tag);
    logic [63:0] ei, ep, ee, ei0, ep0, ee0;
    model(1'b1, ei, ep, ee);
    model(1'b0, ei0, ep0, ee0);
    chk({tag, "_valid"}, valid1, 1);  chk({tag, "_ready"}, ready1, 0);
    chk({tag, "_idx"}, idx1, ei);     chk({tag, "_pow"}, pow1, ep);
    chk({tag, "_energy"}, en1, ee);   chk({tag, "_cnt"}, cnt1, 64'(exp_frames & 16'hFFFF));
    chk({tag, "_valid0"}, valid0, 1);
    chk({tag, "_idx0"}, idx0, ei0);   chk({tag, "_pow0"}, pow0, ep0);
    chk({tag, "_energy0"}, en0, ee0);
  endtask

  // Full frame, report held for `hold` extra cycles with junk beats offered, then released.
  task automatic run_frame(input string tag, input int hold);
    send_beats(N);
    @(negedge clk);
    fft_in_valid = 1'b0;
    exp_frames++;
    check_report(tag);
    for (int h = 0; h < hold; h++) begin
      fft_in_valid = 1'b1;
      fft_in_data  = $urandom;
      @(negedge clk);
      check_report({tag, "_hold"});
    end
    fft_in_valid = 1'b0;
    peak_ready   = 1'b1;
    @(negedge clk);
    peak_ready = 1'b0;
    chk({tag, "_rel_valid"}, valid1, 0);
    chk({tag, "_rel_ready"}, ready1, 1);
    chk({tag, "_rel_cnt"}, cnt1, 64'(exp_frames & 16'hFFFF));
  endtask

  initial begin
    rst_ni = 1'b0; fft_in_valid = 1'b0; fft_in_data = '0; peak_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst_ni = 1'b1;

    zero_frame(); set_bin(3, 100, -50);
    run_frame("single", 0);
    chk("single_idx_c", idx1, 3); chk("single_pow_c", pow1, 12500);
    chk("single_en_c", en1, 12500); chk("single_cnt_c", cnt1, 1);

    zero_frame(); set_bin(2, 10, 0); set_bin(5, 10, 0);
    run_frame("tie", 0);
    chk("tie_idx_c", idx1, 2); chk("tie_en_c", en1, 200);

    zero_frame(); set_bin(0, 1000, 0); set_bin(4, 3, 4);
    run_frame("dc", 0);
    chk("dc_idx_c", idx1, 4); chk("dc_en_c", en1, 1000025);
    chk("dc_idx0_c", idx0, 0); chk("dc_pow0_c", pow0, 1000000);

    for (int i = 0; i < N; i++) set_bin(i, -32768, -32768);
    run_frame("max", 0);
    chk("max_idx_c", idx1, 1); chk("max_pow_c", pow1, 64'd2147483648);
    chk("max_en_c", en1, 64'd17179869184);

    zero_frame();
    run_frame("zero", 0);
    chk("zero_idx_c", idx1, 1); chk("zero_idx0_c", idx0, 0);

    for (int i = 0; i < N; i++) frame[i] = $urandom;
    run_frame("stall", 5);
    for (int i = 0; i < N; i++) frame[i] = $urandom;
    run_frame("after_stall", 0);

    zero_frame(); set_bin(2, 500, 0);
    send_beats(4);
    @(negedge clk);
    fft_in_valid = 1'b0;
    rst_ni = 1'b0;
    exp_frames = 0;
    @(negedge clk);
    check_reset();
    rst_ni = 1'b1;
    zero_frame(); set_bin(6, 7, 0);
    run_frame("post_rst", 0);
    chk("post_rst_idx_c", idx1, 6); chk("post_rst_pow_c", pow1, 49);
    chk("post_rst_cnt_c", cnt1, 1);

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++) begin
        if (k % 2 == 0) set_bin(i, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
        else            frame[i] = $urandom;
      end
      run_frame("rand", int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
